// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: decodes IF/ID into ALU opcode/operands,
// forwards MEM/WB results, detects load/ALU hazards and inserts bubbles on stall or flush.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_id_valid,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_flush,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic        mem_memread,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [4:0]  ex_aluop,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [OPW-1:0] ALU_NONE = 5'b00000;
  localparam logic [OPW-1:0] ALU_ADD  = 5'b00001;
  localparam logic [OPW-1:0] ALU_ADDU = 5'b00010;
  localparam logic [OPW-1:0] ALU_SUBU = 5'b00011;
  localparam logic [OPW-1:0] ALU_AND  = 5'b00100;
  localparam logic [OPW-1:0] ALU_OR   = 5'b00101;
  localparam logic [OPW-1:0] ALU_SLT  = 5'b00110;
  localparam logic [OPW-1:0] ALU_LUI  = 5'b00111;
  localparam logic [OPW-1:0] ALU_BEQ  = 5'b01000;

  logic [5:0]      opcode, funct;
  logic [RW-1:0]   rs, rt, rd;
  logic [15:0]     imm;
  logic            unused_shamt;

  assign opcode       = if_id_instr[31:26];
  assign rs           = if_id_instr[25:21];
  assign rt           = if_id_instr[20:16];
  assign rd           = if_id_instr[15:11];
  assign funct        = if_id_instr[5:0];
  assign imm          = if_id_instr[15:0];
  assign unused_shamt = ^if_id_instr[10:6];

  logic            dec_valid, use_rs, use_rt, use_imm, imm_sext, dst_rd;
  logic            dec_rw, dec_mr, dec_mw;
  logic [OPW-1:0]  dec_aluop;

  // Instruction decode; unknown opcodes/functs leave dec_valid low (bubble)
  always_comb begin
    dec_valid = 1'b0;
    dec_aluop = ALU_NONE;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    use_imm   = 1'b0;
    imm_sext  = 1'b0;
    dst_rd    = 1'b0;
    dec_rw    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'b100000: dec_aluop = ALU_ADD;
          6'b100001: dec_aluop = ALU_ADDU;
          6'b100011: dec_aluop = ALU_SUBU;
          6'b100100: dec_aluop = ALU_AND;
          6'b100101: dec_aluop = ALU_OR;
          6'b101010: dec_aluop = ALU_SLT;
          default:   dec_aluop = ALU_NONE;
        endcase
        dec_valid = (dec_aluop != ALU_NONE);
        use_rs    = dec_valid;
        use_rt    = dec_valid;
        dst_rd    = dec_valid;
        dec_rw    = dec_valid;
      end
      OP_ADDI:  begin dec_valid = 1'b1; dec_aluop = ALU_ADD;  use_rs = 1'b1; use_imm = 1'b1; imm_sext = 1'b1; dec_rw = 1'b1; end
      OP_ADDIU: begin dec_valid = 1'b1; dec_aluop = ALU_ADDU; use_rs = 1'b1; use_imm = 1'b1; imm_sext = 1'b1; dec_rw = 1'b1; end
      OP_ORI:   begin dec_valid = 1'b1; dec_aluop = ALU_OR;   use_rs = 1'b1; use_imm = 1'b1; dec_rw = 1'b1; end
      OP_LUI:   begin dec_valid = 1'b1; dec_aluop = ALU_LUI;  use_imm = 1'b1; dec_rw = 1'b1; end
      OP_LW:    begin dec_valid = 1'b1; dec_aluop = ALU_ADDU; use_rs = 1'b1; use_imm = 1'b1; imm_sext = 1'b1; dec_rw = 1'b1; dec_mr = 1'b1; end
      OP_SW:    begin dec_valid = 1'b1; dec_aluop = ALU_ADDU; use_rs = 1'b1; use_rt = 1'b1; use_imm = 1'b1; imm_sext = 1'b1; dec_mw = 1'b1; end
      OP_BEQ:   begin dec_valid = 1'b1; dec_aluop = ALU_BEQ;  use_rs = 1'b1; use_rt = 1'b1; end
      default:  ;
    endcase
  end

  // Operand forwarding: MEM (non-load) beats WB beats register file; $0 is hard zero
  logic [XLEN-1:0] rs_fwd, rt_fwd;
  assign rs_fwd = (rs == '0) ? '0 :
                  (mem_regwrite && !mem_memread && mem_rd == rs) ? mem_result :
                  (wb_regwrite && wb_rd == rs) ? wb_result : rs_data;
  assign rt_fwd = (rt == '0) ? '0 :
                  (mem_regwrite && !mem_memread && mem_rd == rt) ? mem_result :
                  (wb_regwrite && wb_rd == rt) ? wb_result : rt_data;

  // A source is busy while its producer sits in EXE, or is a load still in MEM
  logic haz_rs, haz_rt, hazard;
  assign haz_rs = use_rs && (rs != '0) &&
                  ((ex_valid && ex_regwrite && ex_rd == rs) ||
                   (mem_regwrite && mem_memread && mem_rd == rs));
  assign haz_rt = use_rt && (rt != '0) &&
                  ((ex_valid && ex_regwrite && ex_rd == rt) ||
                   (mem_regwrite && mem_memread && mem_rd == rt));
  assign hazard = dec_valid && (haz_rs || haz_rt);
  assign stall  = if_id_valid && hazard && !ex_flush;

  logic            load;
  logic [XLEN-1:0] nxt_b;
  logic [RW-1:0]   nxt_rd;
  assign load   = if_id_valid && dec_valid && !ex_flush && !hazard;
  assign nxt_b  = !use_imm ? rt_fwd :
                  imm_sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  assign nxt_rd = dst_rd ? rd : (dec_rw ? rt : '0);

  // ID/EX latch: decoded instruction or all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_aluop      <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
    end else if (load) begin
      ex_valid      <= 1'b1;
      ex_aluop      <= dec_aluop;
      ex_a          <= rs_fwd;
      ex_b          <= nxt_b;
      ex_store_data <= dec_mw ? rt_fwd : '0;
      ex_rd         <= nxt_rd;
      ex_regwrite   <= dec_rw;
      ex_memread    <= dec_mr;
      ex_memwrite   <= dec_mw;
    end else begin
      ex_valid      <= 1'b0;
      ex_aluop      <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: mnemonic-level reference model checked every cycle,
// plus directed instruction sequences with hand-computed expectations.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_id_valid;
  logic [31:0] if_id_instr, rs_data, rt_data;
  logic        ex_flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite, mem_memread;
  logic [31:0] mem_result, wb_result;
  logic        stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]  ex_aluop, ex_rd;
  logic [31:0] ex_a, ex_b, ex_store_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .rs_data(rs_data), .rt_data(rt_data), .ex_flush(ex_flush),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_memread(mem_memread), .mem_result(mem_result), .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {I_ILL, I_ADD, I_ADDU, I_SUBU, I_AND, I_OR, I_SLT,
                I_ADDI, I_ADDIU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ} mn_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  aluop;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } ex_t;

  ex_t mstate = '0;

  function automatic mn_t classify(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'd0) begin
      case (fn)
        6'h20: return I_ADD;
        6'h21: return I_ADDU;
        6'h23: return I_SUBU;
        6'h24: return I_AND;
        6'h25: return I_OR;
        6'h2a: return I_SLT;
        default: return I_ILL;
      endcase
    end
    case (op)
      6'h08: return I_ADDI;
      6'h09: return I_ADDIU;
      6'h0d: return I_ORI;
      6'h0f: return I_LUI;
      6'h23: return I_LW;
      6'h2b: return I_SW;
      6'h04: return I_BEQ;
      default: return I_ILL;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input mn_t m);
    case (m)
      I_ADD, I_ADDI:         return 5'd1;
      I_ADDU, I_ADDIU, I_LW, I_SW: return 5'd2;
      I_SUBU:                return 5'd3;
      I_AND:                 return 5'd4;
      I_OR, I_ORI:           return 5'd5;
      I_SLT:                 return 5'd6;
      I_LUI:                 return 5'd7;
      I_BEQ:                 return 5'd8;
      default:               return 5'd0;
    endcase
  endfunction

  function automatic logic is_r(input mn_t m);
    return m inside {I_ADD, I_ADDU, I_SUBU, I_AND, I_OR, I_SLT};
  endfunction

  function automatic logic reads_rs(input mn_t m);
    return is_r(m) || (m inside {I_ADDI, I_ADDIU, I_ORI, I_LW, I_SW, I_BEQ});
  endfunction

  function automatic logic reads_rt(input mn_t m);
    return is_r(m) || (m inside {I_SW, I_BEQ});
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (mem_regwrite && !mem_memread && mem_rd == r) return mem_result;
    if (wb_regwrite && wb_rd == r) return wb_result;
    return rf;
  endfunction

  function automatic logic busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (mstate.valid && mstate.rw && mstate.rd == r) ||
           (mem_regwrite && mem_memread && mem_rd == r);
  endfunction

  function automatic ex_t decode_ref(input logic [31:0] ins);
    ex_t  e;
    mn_t  m;
    logic [31:0] sx, zx;
    e  = '0;
    m  = classify(ins);
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'd0, ins[15:0]};
    if (m != I_ILL) begin
      e.valid = 1'b1;
      e.aluop = alu_of(m);
      e.a     = reg_value(ins[25:21], rs_data);
      if (is_r(m) || m == I_BEQ)        e.b = reg_value(ins[20:16], rt_data);
      else if (m inside {I_ORI, I_LUI}) e.b = zx;
      else                              e.b = sx;
      e.sd = (m == I_SW) ? reg_value(ins[20:16], rt_data) : 32'd0;
      if (is_r(m)) e.rd = ins[15:11];
      else if (m inside {I_ADDI, I_ADDIU, I_ORI, I_LUI, I_LW}) e.rd = ins[20:16];
      e.rw = !(m inside {I_SW, I_BEQ});
      e.mr = (m == I_LW);
      e.mw = (m == I_SW);
    end
    return e;
  endfunction

  // Compare process: stall mid-cycle, ID/EX contents just after every edge
  initial begin
    ex_t  nxt;
    mn_t  m;
    logic hz, exp_stall;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) mstate = '0;
      m   = classify(if_id_instr);
      hz  = (reads_rs(m) && busy(if_id_instr[25:21])) || (reads_rt(m) && busy(if_id_instr[20:16]));
      exp_stall = if_id_valid && hz && !ex_flush;
      chk("model_stall", 32'(stall), 32'(exp_stall));
      nxt = (if_id_valid && !ex_flush && !hz) ? decode_ref(if_id_instr) : '0;
      @(posedge clk);
      #1;
      mstate = rst_n ? nxt : '0;
      chk("model_valid", 32'(ex_valid), 32'(mstate.valid));
      chk("model_aluop", 32'(ex_aluop), 32'(mstate.aluop));
      chk("model_a", ex_a, mstate.a);
      chk("model_b", ex_b, mstate.b);
      chk("model_rd", 32'(ex_rd), 32'(mstate.rd));
      chk("model_rw", 32'(ex_regwrite), 32'(mstate.rw));
      chk("model_mr", 32'(ex_memread), 32'(mstate.mr));
      chk("model_mw", 32'(ex_memwrite), 32'(mstate.mw));
      if (mstate.mw) chk("model_sd", ex_store_data, mstate.sd);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] fn);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
    @(negedge clk);
    rst_n        = 1'b1;
    if_id_valid  = 1'b1;
    if_id_instr  = ins;
    rs_data      = rsd;
    rt_data      = rtd;
    ex_flush     = 1'b0;
    mem_regwrite = 1'b0;
    mem_memread  = 1'b0;
    wb_regwrite  = 1'b0;
  endtask

  task automatic mid_stall(input string name, input logic exp);
    #2;
    chk(name, 32'(stall), 32'(exp));
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_id_valid = 1'b0; if_id_instr = '0; rs_data = '0; rt_data = '0;
    ex_flush = 1'b0; mem_rd = '0; wb_rd = '0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    mem_memread = 1'b0; mem_result = '0; wb_result = '0;
    after_edge();
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_aluop", 32'(ex_aluop), 32'd0);

    // addi $1,$0,5
    issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 32'd0, 32'd0);
    mid_stall("addi_stall", 1'b0);
    after_edge();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_aluop", 32'(ex_aluop), 32'd1);
    chk("addi_a", ex_a, 32'd0);
    chk("addi_b", ex_b, 32'd5);
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_rw", 32'(ex_regwrite), 32'd1);

    // add $3,$1,$2 right behind: one stall, then forwarded from MEM
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd0, 32'd7);
    mid_stall("add_stall1", 1'b1);
    after_edge();
    chk("add_bubble", 32'(ex_valid), 32'd0);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd0, 32'd7);
    mem_rd = 5'd1; mem_regwrite = 1'b1; mem_result = 32'd5;
    mid_stall("add_stall2", 1'b0);
    after_edge();
    chk("add_fwd_a", ex_a, 32'd5);
    chk("add_b", ex_b, 32'd7);

    issue(itype(6'h0d, 5'd0, 5'd2, 16'hFFFF), 32'd0, 32'd0);
    after_edge();
    chk("ori_b", ex_b, 32'h0000FFFF);
    issue(itype(6'h09, 5'd0, 5'd2, 16'hFFFF), 32'd0, 32'd0);
    after_edge();
    chk("addiu_b", ex_b, 32'hFFFFFFFF);
    chk("addiu_aluop", 32'(ex_aluop), 32'd2);

    // lw $4,0($1) then subu $5,$4,$4: two stalls, then from WB
    issue(itype(6'h23, 5'd1, 5'd4, 16'd0), 32'h100, 32'd0);
    after_edge();
    chk("lw_mr", 32'(ex_memread), 32'd1);
    chk("lw_a", ex_a, 32'h100);
    issue(rtype(5'd4, 5'd4, 5'd5, 6'h23), 32'h1111, 32'h1111);
    mid_stall("subu_stall_ex", 1'b1);
    after_edge();
    issue(rtype(5'd4, 5'd4, 5'd5, 6'h23), 32'h1111, 32'h1111);
    mem_rd = 5'd4; mem_regwrite = 1'b1; mem_memread = 1'b1;
    mid_stall("subu_stall_mem", 1'b1);
    after_edge();
    chk("subu_bubble", 32'(ex_valid), 32'd0);
    issue(rtype(5'd4, 5'd4, 5'd5, 6'h23), 32'h1111, 32'h1111);
    wb_rd = 5'd4; wb_regwrite = 1'b1; wb_result = 32'hDEAD;
    mid_stall("subu_go", 1'b0);
    after_edge();
    chk("subu_a", ex_a, 32'hDEAD);
    chk("subu_b", ex_b, 32'hDEAD);
    chk("subu_aluop", 32'(ex_aluop), 32'd3);

    // hazard together with flush
    issue(rtype(5'd5, 5'd0, 5'd6, 6'h20), 32'd1, 32'd1);
    ex_flush = 1'b1;
    mid_stall("flush_stall", 1'b0);
    after_edge();
    chk("flush_bubble", 32'(ex_valid), 32'd0);

    issue(32'hFC00_0000 | 32'h0021_0005, 32'd3, 32'd4);
    after_edge();
    chk("illegal_bubble", 32'(ex_valid), 32'd0);
    chk("illegal_aluop", 32'(ex_aluop), 32'd0);

    // $0 as producer and consumer: never a hazard, always reads 0
    issue(itype(6'h08, 5'd0, 5'd0, 16'd1), 32'd0, 32'd0);
    after_edge();
    issue(rtype(5'd0, 5'd0, 5'd7, 6'h20), 32'hFFFFFFFF, 32'hFFFFFFFF);
    mem_rd = 5'd0; mem_regwrite = 1'b1; mem_memread = 1'b1;
    mid_stall("r0_stall", 1'b0);
    after_edge();
    chk("r0_a", ex_a, 32'd0);
    chk("r0_b", ex_b, 32'd0);

    // MEM forward beats WB forward
    issue(rtype(5'd1, 5'd1, 5'd10, 6'h21), 32'd9, 32'd9);
    mem_rd = 5'd1; mem_regwrite = 1'b1; mem_result = 32'hAA;
    wb_rd = 5'd1; wb_regwrite = 1'b1; wb_result = 32'hBB;
    after_edge();
    chk("prio_a", ex_a, 32'hAA);

    // sw $2,-4($3) with store data forwarded from WB
    issue(itype(6'h2b, 5'd3, 5'd2, 16'hFFFC), 32'h200, 32'hABCD);
    wb_rd = 5'd2; wb_regwrite = 1'b1; wb_result = 32'h55;
    after_edge();
    chk("sw_b", ex_b, 32'hFFFFFFFC);
    chk("sw_sd", ex_store_data, 32'h55);
    chk("sw_rw", 32'(ex_regwrite), 32'd0);
    chk("sw_mw", 32'(ex_memwrite), 32'd1);

    issue(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'd3, 32'd4);
    after_edge();
    chk("beq_aluop", 32'(ex_aluop), 32'd8);
    chk("beq_b", ex_b, 32'd4);
    issue(itype(6'h0f, 5'd0, 5'd9, 16'h1234), 32'd0, 32'd0);
    after_edge();
    chk("lui_b", ex_b, 32'h1234);
    chk("lui_aluop", 32'(ex_aluop), 32'd7);
    issue(rtype(5'd1, 5'd2, 5'd11, 6'h2a), 32'd1, 32'd2);
    after_edge();
    chk("slt_aluop", 32'(ex_aluop), 32'd6);
    issue(rtype(5'd1, 5'd2, 5'd12, 6'h24), 32'hF0, 32'h3C);
    after_edge();
    issue(rtype(5'd1, 5'd2, 5'd13, 6'h25), 32'hF0, 32'h3C);
    after_edge();

    issue(itype(6'h08, 5'd1, 5'd14, 16'd2), 32'd1, 32'd0);
    if_id_valid = 1'b0;
    after_edge();
    chk("novalid_bubble", 32'(ex_valid), 32'd0);

    // asynchronous reset mid-cycle, then first edge latches normally
    issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 32'd0, 32'd0);
    after_edge();
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(ex_valid), 32'd0);
    chk("areset_b", ex_b, 32'd0);
    chk("areset_aluop", 32'(ex_aluop), 32'd0);
    @(negedge clk);
    after_edge();
    issue(itype(6'h08, 5'd0, 5'd1, 16'd6), 32'd0, 32'd0);
    after_edge();
    chk("post_reset_valid", 32'(ex_valid), 32'd1);
    chk("post_reset_b", ex_b, 32'd6);

    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage plus ID/EX pipeline register for the 5-stage pipelined CPU; the producing end of the EXE-stage ALU interface. It decodes the IF/ID instruction into the 5-bit ALU opcode and operand pair the EXE-stage ALU consumes. It forwards MEM/WB results into the operands and detects EXE/MEM-stage data hazards. It registers everything into the ID/EX latch, inserting bubbles on stall or flush.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 32 registers)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_id_valid  in  1  IF/ID latch holds a real instruction
- if_id_instr  in  32  instruction from IF/ID
- rs_data, rt_data  in  32 each  register-file read data for instr[25:21], instr[20:16]
- ex_flush  in  1  branch taken in EXE; kill the instruction in ID
- mem_rd, wb_rd  in  5 each  destination register of the MEM and WB stage instructions
- mem_regwrite, wb_regwrite  in  1 each  MEM/WB stage will write mem_rd/wb_rd
- mem_memread  in  1  MEM-stage instruction is a load
- mem_result, wb_result  in  32 each  forwardable results
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_aluop  out  5  ALU opcode
- ex_a, ex_b  out  32 each  ALU operands
- ex_store_data  out  32  forwarded rt value for sw
- ex_rd  out  5  destination register
- ex_regwrite, ex_memread, ex_memwrite  out  1 each  control bits

## Operation
Decode into aluop. Anything else decodes as a bubble.
- R-type (op 000000), by funct:
  - add 100000 -> 00001
  - addu 100001 -> 00010
  - subu 100011 -> 00011
  - and 100100 -> 00100
  - or 100101 -> 00101
  - slt 101010 -> 00110
- addi 001000 -> 00001
- addiu 001001 -> 00010
- ori 001101 -> 00101
- lui 001111 -> 00111
- lw 100011 -> 00010
- sw 101011 -> 00010
- beq 000100 -> 01000

Operands and destination:
- ex_a = forwarded rs.
- ex_b = forwarded rt for R-type/beq. Otherwise the immediate:
  - sign-extended for addi/addiu/lw/sw
  - zero-extended for ori/lui
- lui: ex_b is the raw zero-extended imm; the ALU performs the shift.
- Destination: rd for R-type; rt for addi/addiu/ori/lui/lw.
- regwrite = 0 for sw, beq, and bubbles.
- ex_memread = lw; ex_memwrite = sw.

Sources read:
- R-type, sw, beq: rs and rt
- addi/addiu/ori/lw: rs only
- lui: none

Forwarding, per read source s (reg != 0):
- MEM wins: mem_regwrite & mem_rd==s & !mem_memread -> mem_result.
- Else WB: wb_regwrite & wb_rd==s -> wb_result.
- Else regfile data.
- Register 0 always reads 0.

Hazard (stall), for any read source s != 0. Stall when:
- the ID/EX latch holds ex_valid & ex_regwrite & ex_rd==s, or
- the MEM stage has mem_regwrite & mem_memread & mem_rd==s.

Stall output:
- stall = if_id_valid & hazard & !ex_flush.
- On stall, load a bubble into ID/EX.

## Timing
- ID/EX outputs are registered and update on the rising clk edge.
- stall is combinational from the current inputs and the current ID/EX contents.
- Reset (rst_n=0, asynchronous): all registered outputs are 0, i.e. ex_valid=0 and aluop=00000.
- Bubble: valid, all control bits, aluop and ex_rd are 0; operands are 0.
- Priority at the edge: reset > ex_flush (bubble) > stall (bubble) > !if_id_valid (bubble) > decoded load.
- Flush and stall in the same cycle: flush wins and stall is 0.
- Dependency on a non-load in EXE: exactly 1 stall cycle, then the value is forwarded from MEM.
- Dependency on a load in EXE: 2 stall cycles (EXE, then MEM-load), then forwarded from WB.
- Latency: one cycle from IF/ID to ID/EX outputs.
- Reset deassertion mid-stream: the first edge latches normally.

## Test plan
- Reset, then addi $1,$0,5 with rs_data=0 -> next edge: ex_valid=1, aluop=00001, a=0, b=5, rd=1, regwrite=1, stall=0.
- ori $2,$0,0xFFFF -> b=0x0000FFFF. addiu $2,$0,0xFFFF -> b=0xFFFFFFFF, aluop=00010.
- add $3,$1,$2 immediately after addi $1 -> stall=1 for one cycle and a bubble in ID/EX. Next cycle mem_rd=1, mem_result=5 -> ex_a=5.
- lw $4,0($1) followed by subu $5,$4,$4 -> stall for 2 cycles. Then, with wb_rd=4, wb_result=0xDEAD -> a=b=0xDEAD, aluop=00011.
- Hazard and ex_flush asserted together -> stall=0 and a bubble is latched.
- rst_n pulled low mid-stream without a clock -> outputs go to 0 immediately.
- Illegal opcode 111111 -> bubble.
- Dependency on $0 -> no stall, operand 0.
